// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // Decimal digits needed to hold the largest unsigned value of bin_w bits.
    function automatic int bcd_min_digits(input int bin_w);
        longint unsigned v;
        int n;
        v = (64'd1 << bin_w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so the next
// left shift carries correctly into the following decimal digit.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble converter: one binary bit per clock, valid/ready on both
// sides, result held with a sticky overflow flag and significant-digit count.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter  int BIN_W  = 8,
    parameter  int DIGITS = 3,
    localparam int CNT_W  = $clog2(BIN_W + 1),
    localparam int SIG_W  = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [SIG_W-1:0]      sig_digits,
    output logic                  overflow
);

    localparam int               SR_W       = 4 * DIGITS + BIN_W;
    localparam int               MIN_DIGITS = bcd_min_digits(BIN_W);
    localparam bit               CAN_OVF    = (DIGITS < MIN_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    generate
        if (BIN_W < 1 || BIN_W > 32 || DIGITS < 1 || DIGITS > 10) begin : g_bad_params
            $error("bcd_seq_converter: BIN_W must be 1..32 and DIGITS 1..10");
        end
    endgenerate

    bcd_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic [4*DIGITS-1:0]  dig_q, dig_d, dig_adj;
    logic                 ovf_q, ovf_d;
    logic                 vld_q, vld_d;
    logic [SR_W-1:0]      sr_adj;
    logic [SIG_W-1:0]     sig;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (dig_q[4*g +: 4]),
            .digit_o (dig_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        sr_adj  = {dig_adj, bin_q};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = bin_in;
                    dig_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The bit leaving the top digit is lost; only a too-narrow result can lose a 1.
                {dig_d, bin_d} = {sr_adj[SR_W-2:0], 1'b0};
                ovf_d          = ovf_q | (CAN_OVF & sr_adj[SR_W-1]);
                cnt_d          = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    vld_d   = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    // Highest nonzero digit wins; an all-zero result still reports one digit.
    always_comb begin
        sig = SIG_W'(1);
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_q[4*k +: 4] != 4'd0) begin
                sig = SIG_W'(k + 1);
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = vld_q;
    assign bcd_out    = dig_q;
    assign sig_digits = sig;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter over five parameter sets, plus an
// exhaustive 8-bit sweep with random consumer stalls.
module tb_bcd_seq_converter;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    // idx0: BIN_W=8  DIGITS=3 (default)
    logic        iv0, ir0, ov0, or0, ovf0;
    logic [7:0]  bin0;
    logic [11:0] bcd0;
    logic [1:0]  sig0;
    // idx1: BIN_W=8  DIGITS=2
    logic        iv1, ir1, ov1, or1, ovf1;
    logic [7:0]  bin1;
    logic [7:0]  bcd1;
    logic [1:0]  sig1;
    // idx2: BIN_W=16 DIGITS=5
    logic        iv2, ir2, ov2, or2, ovf2;
    logic [15:0] bin2;
    logic [19:0] bcd2;
    logic [2:0]  sig2;
    // idx3: BIN_W=4  DIGITS=1
    logic        iv3, ir3, ov3, or3, ovf3;
    logic [3:0]  bin3;
    logic [3:0]  bcd3;
    logic [0:0]  sig3;
    // idx4: BIN_W=1  DIGITS=1
    logic        iv4, ir4, ov4, or4, ovf4;
    logic [0:0]  bin4;
    logic [3:0]  bcd4;
    logic [0:0]  sig4;

    bcd_seq_converter u_def (
        .clk(clk), .reset_n(reset_n), .in_valid(iv0), .in_ready(ir0), .bin_in(bin0),
        .out_valid(ov0), .out_ready(or0), .bcd_out(bcd0), .sig_digits(sig0), .overflow(ovf0)
    );
    bcd_seq_converter #(.BIN_W(8), .DIGITS(2)) u_d2 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1), .bin_in(bin1),
        .out_valid(ov1), .out_ready(or1), .bcd_out(bcd1), .sig_digits(sig1), .overflow(ovf1)
    );
    bcd_seq_converter #(.BIN_W(16), .DIGITS(5)) u_w16 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv2), .in_ready(ir2), .bin_in(bin2),
        .out_valid(ov2), .out_ready(or2), .bcd_out(bcd2), .sig_digits(sig2), .overflow(ovf2)
    );
    bcd_seq_converter #(.BIN_W(4), .DIGITS(1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv3), .in_ready(ir3), .bin_in(bin3),
        .out_valid(ov3), .out_ready(or3), .bcd_out(bcd3), .sig_digits(sig3), .overflow(ovf3)
    );
    bcd_seq_converter #(.BIN_W(1), .DIGITS(1)) u_w1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir4), .bin_in(bin4),
        .out_valid(ov4), .out_ready(or4), .bcd_out(bcd4), .sig_digits(sig4), .overflow(ovf4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int i, input logic v, input logic [31:0] b);
        case (i)
            0: begin iv0 = v; bin0 = b[7:0];  end
            1: begin iv1 = v; bin1 = b[7:0];  end
            2: begin iv2 = v; bin2 = b[15:0]; end
            3: begin iv3 = v; bin3 = b[3:0];  end
            default: begin iv4 = v; bin4 = b[0:0]; end
        endcase
    endtask

    task automatic set_ordy(input int i, input logic v);
        case (i)
            0: or0 = v;
            1: or1 = v;
            2: or2 = v;
            3: or3 = v;
            default: or4 = v;
        endcase
    endtask

    function automatic logic g_ir(input int i);
        case (i)
            0: return ir0;
            1: return ir1;
            2: return ir2;
            3: return ir3;
            default: return ir4;
        endcase
    endfunction

    function automatic logic g_ov(input int i);
        case (i)
            0: return ov0;
            1: return ov1;
            2: return ov2;
            3: return ov3;
            default: return ov4;
        endcase
    endfunction

    function automatic logic g_ovf(input int i);
        case (i)
            0: return ovf0;
            1: return ovf1;
            2: return ovf2;
            3: return ovf3;
            default: return ovf4;
        endcase
    endfunction

    function automatic logic [63:0] g_bcd(input int i);
        case (i)
            0: return 64'(bcd0);
            1: return 64'(bcd1);
            2: return 64'(bcd2);
            3: return 64'(bcd3);
            default: return 64'(bcd4);
        endcase
    endfunction

    function automatic logic [63:0] g_sig(input int i);
        case (i)
            0: return 64'(sig0);
            1: return 64'(sig1);
            2: return 64'(sig2);
            3: return 64'(sig3);
            default: return 64'(sig4);
        endcase
    endfunction

    function automatic logic [63:0] ref_bcd(input int v, input int digits);
        logic [63:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_sig(input int v);
        int n;
        int x;
        n = 1;
        x = v;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        return 64'(n);
    endfunction

    // One transaction: accept, measure latency, check result, optional stall, consume.
    task automatic conv(input int idx, input logic [31:0] b, input int lat,
                        input logic [63:0] eb, input logic [63:0] es, input logic eo,
                        input int stall, input string tag);
        int cnt;
        chk({tag, "_in_ready_idle"}, 64'(g_ir(idx)), 64'd1);
        set_in(idx, 1'b1, b);
        step(1);
        set_in(idx, 1'b0, ~b);
        chk({tag, "_in_ready_busy"}, 64'(g_ir(idx)), 64'd0);
        cnt = 0;
        while (!g_ov(idx) && cnt < 64) begin
            step(1);
            cnt++;
        end
        chk({tag, "_latency"}, 64'(cnt), 64'(lat));
        chk({tag, "_bcd"}, g_bcd(idx), eb);
        chk({tag, "_sig"}, g_sig(idx), es);
        chk({tag, "_ovf"}, 64'(g_ovf(idx)), 64'(eo));
        for (int s = 0; s < stall; s++) begin
            set_in(idx, 1'b1, b ^ 32'h55);
            chk({tag, "_stall_valid"}, 64'(g_ov(idx)), 64'd1);
            chk({tag, "_stall_bcd"}, g_bcd(idx), eb);
            chk({tag, "_stall_in_ready"}, 64'(g_ir(idx)), 64'd0);
            step(1);
        end
        set_in(idx, 1'b0, 32'd0);
        set_ordy(idx, 1'b1);
        step(1);
        set_ordy(idx, 1'b0);
        chk({tag, "_consumed_valid"}, 64'(g_ov(idx)), 64'd0);
        chk({tag, "_consumed_in_ready"}, 64'(g_ir(idx)), 64'd1);
    endtask

    initial begin
        int results;
        int w;
        bit got;
        checks  = 0;
        errors  = 0;
        results = 0;
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(i, 1'b0, 32'd0);
            set_ordy(i, 1'b0);
        end
        step(2);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            chk("reset_in_ready", 64'(g_ir(i)), 64'd1);
            chk("reset_out_valid", 64'(g_ov(i)), 64'd0);
            chk("reset_bcd", g_bcd(i), 64'd0);
            chk("reset_sig", g_sig(i), 64'd1);
            chk("reset_ovf", 64'(g_ovf(i)), 64'd0);
        end

        conv(0, 32'd255, 8, 64'h255, 64'd3, 1'b0, 0, "d255");
        conv(0, 32'd0,   8, 64'h000, 64'd1, 1'b0, 0, "d0");
        conv(0, 32'd9,   8, 64'h009, 64'd1, 1'b0, 0, "d9");
        conv(0, 32'd100, 8, 64'h100, 64'd3, 1'b0, 20, "d100_stall");

        // Reset in the middle of a conversion of 200.
        set_in(0, 1'b1, 32'd200);
        step(1);
        set_in(0, 1'b0, 32'd0);
        step(3);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        chk("abort_in_ready", 64'(ir0), 64'd1);
        chk("abort_out_valid", 64'(ov0), 64'd0);
        chk("abort_bcd", 64'(bcd0), 64'd0);
        chk("abort_sig", 64'(sig0), 64'd1);
        for (int c = 0; c < 12; c++) begin
            chk("abort_no_result", 64'(ov0), 64'd0);
            step(1);
        end
        conv(0, 32'd37, 8, 64'h037, 64'd2, 1'b0, 0, "d37_after_abort");

        conv(1, 32'd123, 8, 64'h23, 64'd2, 1'b1, 0, "dig2_123");
        conv(1, 32'd99,  8, 64'h99, 64'd2, 1'b0, 0, "dig2_99");
        conv(1, 32'd200, 8, 64'h00, 64'd1, 1'b1, 0, "dig2_200");

        conv(2, 32'd65535, 16, 64'h65535, 64'd5, 1'b0, 0, "w16_65535");
        conv(2, 32'd1000,  16, 64'h01000, 64'd4, 1'b0, 0, "w16_1000");

        conv(3, 32'd13, 4, 64'h3, 64'd1, 1'b1, 0, "dig1_13");
        conv(3, 32'd9,  4, 64'h9, 64'd1, 1'b0, 0, "dig1_9");
        conv(3, 32'd10, 4, 64'h0, 64'd1, 1'b1, 0, "dig1_10");

        conv(4, 32'd1, 1, 64'h1, 64'd1, 1'b0, 0, "w1_1");
        conv(4, 32'd0, 1, 64'h0, 64'd1, 1'b0, 0, "w1_0");

        // Exhaustive sweep with a randomly stalling consumer.
        for (int v = 0; v < 256; v++) begin
            set_in(0, 1'b1, 32'(v));
            w = 0;
            while (!ir0 && w < 50) begin
                step(1);
                w++;
            end
            if (w >= 50) chk("sweep_accept_timeout", 64'd0, 64'd1);
            step(1);
            set_in(0, 1'b0, 32'd0);
            got = 1'b0;
            for (int c = 0; c < 80 && !got; c++) begin
                or0 = 1'($urandom_range(0, 1));
                if (ov0 && or0) begin
                    got = 1'b1;
                end else begin
                    step(1);
                end
            end
            if (!got) begin
                chk("sweep_result_timeout", 64'd0, 64'd1);
            end else begin
                results++;
                chk("sweep_bcd", 64'(bcd0), ref_bcd(v, 3));
                chk("sweep_sig", 64'(sig0), ref_sig(v));
                chk("sweep_ovf", 64'(ovf0), 64'd0);
            end
            step(1);
            or0 = 1'b0;
            chk("sweep_no_duplicate", 64'(ov0), 64'd0);
        end
        chk("sweep_result_count", 64'(results), 64'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
